// File: rtl/reg_bus_master_pkg.sv
// reg_bus_master_pkg
//   Shared constants and types for the register-bus initiator:
//   data width, register codes, opcodes, FSM state encodings and the
//   packed command entry stored in the command FIFO.
package reg_bus_master_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int REG_W      = 4;

    // Register codes. NONE is reserved and never backed by a register,
    // so driving it on either half of the bus means "no access".
    localparam logic [REG_W-1:0] REG_NONE = 4'hF;
    localparam logic [REG_W-1:0] REG_DR0  = 4'h0;
    localparam logic [REG_W-1:0] REG_DR1  = 4'h1;
    localparam logic [REG_W-1:0] REG_DR2  = 4'h2;
    localparam logic [REG_W-1:0] REG_DR3  = 4'h3;
    localparam logic [REG_W-1:0] REG_CR   = 4'h4;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_LDI = 2'b01,
        OP_RD  = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // 18-bit FIFO entry: {op, src, dst, imm}
    typedef struct packed {
        op_e                   op;
        logic [REG_W-1:0]      src;
        logic [REG_W-1:0]      dst;
        logic [DATA_WIDTH-1:0] imm;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Bus address word: read select in the upper nibble, write select below.
    function automatic logic [DATA_WIDTH-1:0] bus_addr(
        input logic [REG_W-1:0] rsel,
        input logic [REG_W-1:0] wsel
    );
        return {rsel, wsel};
    endfunction

endpackage

// File: rtl/reg_cmd_fifo.sv
// reg_cmd_fifo
//   Synchronous FIFO holding pending register-transfer commands.
//   Ports:
//     clk_i, rst_ni   clock and asynchronous active-low reset
//     push_i, wdata_i write request (ignored while full)
//     pop_i           read request (ignored while empty)
//     rdata_o         head entry, valid whenever empty_o is low
//     full_o, empty_o occupancy flags, decoded from the registered count
//   There is no bypass: an entry written at one edge is visible at the
//   head only after that edge.
module reg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == {(AW+1){1'b0}});
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Entry storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy count; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Register-bus initiator between the execute stage and the register file.
//   Commands arrive on a valid/ready port, are queued in reg_cmd_fifo and
//   sequenced onto the bus; RD results leave on a valid/ready response port.
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     cmd_valid/cmd_ready              command handshake (ready = FIFO not full)
//     cmd_op/cmd_src/cmd_dst/cmd_imm   command fields
//     addr_bus                         {read select, write select}, 8'hFF when idle
//     wr_data                          write data, committed at end of WRITE
//     rd_data                          combinational read data from the register file
//     rsp_valid/rsp_ready/rsp_data     RD result handshake
//     busy                             FSM not idle or commands still queued
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [REG_W-1:0]      cmd_src,
    input  logic [REG_W-1:0]      cmd_dst,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [DATA_WIDTH-1:0] addr_bus,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    localparam logic [DATA_WIDTH-1:0] ADDR_IDLE = 8'hFF;

    state_e                state_q;
    op_e                   cur_op_q;
    logic [REG_W-1:0]      cur_dst_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_valid_q;

    logic [CMD_W-1:0]      push_entry_s;
    logic [CMD_W-1:0]      head_raw_s;
    cmd_t                  head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  pop_s;

    assign push_entry_s = {cmd_op, cmd_src, cmd_dst, cmd_imm};
    assign head_s       = cmd_t'(head_raw_s);

    reg_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (cmd_valid),
        .wdata_i (push_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_raw_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Pop decision: IDLE pops normally, WRITE pops to chain commands back-to-back.
    always_comb begin
        pop_s = 1'b0;
        if (((state_q == ST_IDLE) || (state_q == ST_WRITE)) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Bus sequencing FSM with all bus and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_op_q    <= OP_NOP;
            cur_dst_q   <= REG_NONE;
            addr_q      <= ADDR_IDLE;
            wr_data_q   <= 8'h00;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WRITE: begin
                    if (!fifo_empty_s) begin
                        cur_op_q  <= head_s.op;
                        cur_dst_q <= head_s.dst;
                        case (head_s.op)
                            OP_MOV, OP_RD: begin
                                addr_q  <= bus_addr(head_s.src, REG_NONE);
                                state_q <= ST_READ;
                            end
                            OP_LDI: begin
                                addr_q    <= bus_addr(REG_NONE, head_s.dst);
                                wr_data_q <= head_s.imm;
                                state_q   <= ST_WRITE;
                            end
                            default: begin
                                // NOP: consumed with no bus cycle
                                addr_q  <= ADDR_IDLE;
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        addr_q  <= ADDR_IDLE;
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Only MOV and RD reach READ
                    if (cur_op_q == OP_MOV) begin
                        wr_data_q <= rd_data;
                        addr_q    <= bus_addr(REG_NONE, cur_dst_q);
                        state_q   <= ST_WRITE;
                    end else begin
                        rsp_data_q  <= rd_data;
                        rsp_valid_q <= 1'b1;
                        addr_q      <= ADDR_IDLE;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    addr_q  <= ADDR_IDLE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr_bus  = addr_q;
    assign wr_data   = wr_data_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign cmd_ready = !fifo_full_s;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Bus initiator for the core's common register file. It accepts register-transfer commands through a valid/ready port, buffers them in a small FIFO, and sequences them onto the shared register bus. For each command it drives `addr_bus` (read select in [7:4], write select in [3:0]) and the write data, and it captures read data. Read results return to the requester on a valid/ready response port. It sits between the instruction execute stage and the register file.

## Interface
Parameters:
- CMD_DEPTH, 4: command FIFO depth; power of two, minimum 2.
- Data and address widths are `DATA_WIDTH` (8) from `define.v`.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  opcode: MOV, LDI, RD or NOP.
- cmd_src  in  4  source register code.
- cmd_dst  in  4  destination register code.
- cmd_imm  in  8  immediate value for LDI.
- addr_bus  out  8  {read select, write select} to the register file.
- wr_data  out  8  write data to the register file.
- rd_data  in  8  combinational read data from the register file.
- rsp_valid  out  1  RD result available.
- rsp_ready  in  1  requester accepts the result.
- rsp_data  out  8  RD result.
- busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.

## Operation
- Push: `cmd_valid && cmd_ready` writes {op, src, dst, imm} into the FIFO. `cmd_ready = !full`.
- Opcodes:
  - MOV: copies register src to register dst.
  - LDI: writes imm to dst.
  - RD: reads src and returns the value on the response port.
  - NOP: popped and discarded, no bus activity.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE with FIFO non-empty: pop the head entry.
    - MOV/RD: `addr_bus <= {src, NONE}`, go to READ.
    - LDI: `addr_bus <= {NONE, dst}`, `wr_data <= imm`, go to WRITE.
    - NOP: stay in IDLE.
  - READ, MOV: `wr_data <= rd_data`, `addr_bus <= {NONE, dst}`, go to WRITE.
  - READ, RD: `rsp_data <= rd_data`, `rsp_valid <= 1`, `addr_bus <= {NONE, NONE}`, go to RESP.
  - WRITE: the register file commits at the end of this cycle.
    - If the FIFO is non-empty, pop the next entry directly, using the IDLE pop actions (back-to-back).
    - Otherwise `addr_bus <= {NONE, NONE}`, go to IDLE.
  - RESP: hold `rsp_data` stable. On `rsp_ready`, clear `rsp_valid` and go to IDLE. No bus activity in RESP.
- When not in READ or WRITE, `addr_bus` is 8'hFF ({NONE, NONE}).
- Register codes with no register behind them, including NONE, are issued unchanged. The register file returns 0 for such reads and ignores such writes.
- MOV with src == dst is legal and rewrites the same value.

## Timing
- All outputs are registered, except `cmd_ready` and `busy`, which are decoded from registered state.
- Reset values:
  - `addr_bus` = 8'hFF.
  - `wr_data` = 0, `rsp_data` = 0, `rsp_valid` = 0.
  - FIFO empty, FSM in IDLE, so `cmd_ready` = 1 and `busy` = 0.
- A command pushed at edge E is popped no earlier than edge E+1 (no FIFO bypass).
- Bus occupancy per command: LDI 1 cycle, MOV 2 cycles, RD 1 cycle plus time in RESP.
- Sustained throughput: back-to-back MOVs complete one every 2 cycles; LDIs one per cycle.
- Full FIFO: `cmd_ready` = 0, the push is refused, FIFO contents are unchanged.
- Simultaneous push and pop is legal when not full, including when the FIFO holds a single entry.
- Response port:
  - `rsp_valid` stays high until the handshake completes.
  - Queued commands wait while in RESP.
  - New pushes continue to be accepted while the FIFO is not full.
- Reset asserted mid-operation: all state clears immediately and the FIFO empties. The in-flight write is abandoned, because `addr_bus` goes to 8'hFF before the next edge.

## Structure
- Shared constants in `define.v`:
  - NONE = 4'hF; reserved, never assigned to a register.
  - Opcodes: OP_MOV 2'b00, OP_LDI 2'b01, OP_RD 2'b10, OP_NOP 2'b11.
  - FSM state encodings.
- Sub-module `reg_cmd_fifo`: synchronous FIFO with CMD_DEPTH entries, 18-bit entry width, full/empty flags, asynchronous active-low reset.
- The FSM and output registers live in `reg_bus_master`.

## Test plan
- Reset: after release, expect `addr_bus` = 8'hFF, `cmd_ready` = 1, `busy` = 0, `rsp_valid` = 0.
- LDI dst=DR0, imm=8'h5A, then RD src=DR0:
  - Expect one WRITE cycle with `addr_bus` = {NONE, DR0} and `wr_data` = 8'h5A.
  - Expect `rsp_data` = 8'h5A with `rsp_valid` held until `rsp_ready`.
- LDI DR1=8'h3C, then MOV DR1→CR, then RD CR:
  - Expect the MOV to use a READ cycle with `addr_bus` = {DR1, NONE}, followed by a WRITE cycle with `addr_bus` = {NONE, CR} and `wr_data` = 8'h3C.
  - Expect RD to return 8'h3C.
- Push 6 commands with `rsp_ready` = 0 and the first command a RD:
  - `cmd_ready` falls after 4 entries are held.
  - No bus activity after the RD until `rsp_ready` rises.
  - All remaining commands then complete in order.
- Back-to-back LDIs to DR0..DR3: expect 4 consecutive WRITE cycles with no IDLE gap.
- Assert `rst_n` during the WRITE of a MOV: expect `addr_bus` = 8'hFF asynchronously, FIFO empty, and a NOP queued afterwards consumed with no bus activity.
